// File: rtl/rs_multi_cdb_if.sv
// rs_multi_cdb_if
// Purpose: groups the dispatch, result-bus, issue and flush signals of the
//          multi-bus reservation station into a single bundle.
// Signals:
//   flush                   discard all held entries and the output stage
//   take_valid/take_ready   dispatch handshake, op_*_in/control_in payload,
//                           id_taken = tag given to the entry being taken
//   cdb_valid/rs_id/value   CDB_PORTS result buses, packed port-major
//   output_valid/ready      issue handshake, op_value_out/control_out/
//                           op_rs_id_out payload
//   occupancy               entries held, output stage excluded
// Handshake rule (both directions): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds valid and payload
// steady until that edge; ready may change freely; payload is don't-care
// while valid is low.
// Modports: master = dispatch/execution-unit side, slave = reservation station.
interface rs_multi_cdb_if #(
    parameter int OPERANDS      = 4,
    parameter int RS_ID_WIDTH   = 5,
    parameter int RS_DEPTH      = 8,
    parameter int CDB_PORTS     = 2,
    parameter int CONTROL_WIDTH = 32
);
    localparam int OCC_W = $clog2(RS_DEPTH + 1);

    logic                              flush;
    logic                              take_valid;
    logic                              take_ready;
    logic [OPERANDS-1:0]               op_value_valid_in;
    logic [OPERANDS*RS_ID_WIDTH-1:0]   op_rs_id_in;
    logic [OPERANDS*32-1:0]            op_value_in;
    logic [CONTROL_WIDTH-1:0]          control_in;
    logic [RS_ID_WIDTH-1:0]            id_taken;
    logic [CDB_PORTS-1:0]              cdb_valid;
    logic [CDB_PORTS*RS_ID_WIDTH-1:0]  cdb_rs_id;
    logic [CDB_PORTS*32-1:0]           cdb_value;
    logic                              output_valid;
    logic                              output_ready;
    logic [OPERANDS*32-1:0]            op_value_out;
    logic [CONTROL_WIDTH-1:0]          control_out;
    logic [RS_ID_WIDTH-1:0]            op_rs_id_out;
    logic [OCC_W-1:0]                  occupancy;

    modport master (
        output flush, take_valid, op_value_valid_in, op_rs_id_in, op_value_in, control_in,
        output cdb_valid, cdb_rs_id, cdb_value, output_ready,
        input  take_ready, id_taken, output_valid, op_value_out, control_out,
        input  op_rs_id_out, occupancy
    );

    modport slave (
        input  flush, take_valid, op_value_valid_in, op_rs_id_in, op_value_in, control_in,
        input  cdb_valid, cdb_rs_id, cdb_value, output_ready,
        output take_ready, id_taken, output_valid, op_value_out, control_out,
        output op_rs_id_out, occupancy
    );
endinterface

// File: rtl/rs_multi_cdb.sv
// rs_multi_cdb
// Purpose: reservation station with RS_DEPTH entries that snoops CDB_PORTS
//          result buses (including a bypass at dispatch) and issues the oldest
//          fully-ready entry into a registered output stage. Supports flush
//          and reports occupancy.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   rs_multi_cdb_if.slave: dispatch, CDB, issue, flush, occupancy
module rs_multi_cdb #(
    parameter int OPERANDS      = 4,
    parameter int RS_OFFSET     = 0,
    parameter int RS_DEPTH      = 8,
    parameter int RS_ID_WIDTH   = 5,
    parameter int CDB_PORTS     = 2,
    parameter int CONTROL_WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    rs_multi_cdb_if.slave bus
);
    localparam int OCC_W = $clog2(RS_DEPTH + 1);
    localparam int IDX_W = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0]      r_valid;
    logic [OPERANDS-1:0]      r_op_valid [RS_DEPTH];
    logic [RS_ID_WIDTH-1:0]   r_op_tag   [RS_DEPTH][OPERANDS];
    logic [31:0]              r_op_val   [RS_DEPTH][OPERANDS];
    logic [CONTROL_WIDTH-1:0] r_ctrl     [RS_DEPTH];
    // r_older[i][j] = entry i was taken before entry j (meaningful when both valid)
    logic [RS_DEPTH-1:0]      r_older    [RS_DEPTH];

    logic                     r_out_valid;
    logic [OPERANDS*32-1:0]   r_out_ops;
    logic [CONTROL_WIDTH-1:0] r_out_ctrl;
    logic [RS_ID_WIDTH-1:0]   r_out_id;
    logic [OCC_W-1:0]         r_occ;

    logic                     w_free_any;
    logic [IDX_W-1:0]         w_free_idx;
    logic                     w_take;
    logic [RS_DEPTH-1:0]      w_ready;
    logic [RS_DEPTH-1:0]      w_oldest;
    logic                     w_sel_any;
    logic [IDX_W-1:0]         w_sel_idx;
    logic                     w_load;
    logic [32:0]              w_snp [RS_DEPTH][OPERANDS];
    logic [32:0]              w_byp [OPERANDS];

    // {hit, value} for a tag; lowest port index wins when several match.
    function automatic logic [32:0] f_cdb_match(
        input logic [RS_ID_WIDTH-1:0]           tag,
        input logic [CDB_PORTS-1:0]             vld,
        input logic [CDB_PORTS*RS_ID_WIDTH-1:0] ids,
        input logic [CDB_PORTS*32-1:0]          vals
    );
        logic [32:0] res;
        res = '0;
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (vld[p] && ids[p*RS_ID_WIDTH +: RS_ID_WIDTH] == tag) begin
                res = {1'b1, vals[p*32 +: 32]};
            end
        end
        return res;
    endfunction

    // Lowest free entry index.
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_any = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign bus.take_ready = w_free_any & ~bus.flush;
    assign bus.id_taken   = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(w_free_idx);
    assign w_take         = bus.take_valid & bus.take_ready;

    // Readiness uses registered operand state only, so a CDB hit this cycle
    // makes the entry eligible from the next cycle on.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_ready[i] = r_valid[i] & (&r_op_valid[i]);
        end
    end

    // An entry is the oldest ready one if it is older than every other ready entry.
    always_comb begin
        w_oldest = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_oldest[i] = w_ready[i];
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (j != i && w_ready[j] && !r_older[i][j]) begin
                    w_oldest[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_sel_any = |w_oldest;
        w_sel_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (w_oldest[i]) begin
                w_sel_idx = IDX_W'(i);
            end
        end
    end

    assign w_load = w_sel_any & (~r_out_valid | bus.output_ready);

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int o = 0; o < OPERANDS; o++) begin
                w_snp[i][o] = f_cdb_match(r_op_tag[i][o], bus.cdb_valid, bus.cdb_rs_id, bus.cdb_value);
            end
        end
        for (int o = 0; o < OPERANDS; o++) begin
            w_byp[o] = f_cdb_match(bus.op_rs_id_in[o*RS_ID_WIDTH +: RS_ID_WIDTH],
                                   bus.cdb_valid, bus.cdb_rs_id, bus.cdb_value);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_out_valid <= 1'b0;
            r_out_ops   <= '0;
            r_out_ctrl  <= '0;
            r_out_id    <= '0;
            r_occ       <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_older[i] <= '0;
            end
        end else if (bus.flush) begin
            r_valid     <= '0;
            r_out_valid <= 1'b0;
            r_occ       <= '0;
        end else begin
            // Snoop: only pending operands of held entries capture.
            for (int i = 0; i < RS_DEPTH; i++) begin
                for (int o = 0; o < OPERANDS; o++) begin
                    if (r_valid[i] && !r_op_valid[i][o] && w_snp[i][o][32]) begin
                        r_op_valid[i][o] <= 1'b1;
                        r_op_val[i][o]   <= w_snp[i][o][31:0];
                    end
                end
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                for (int o = 0; o < OPERANDS; o++) begin
                    r_out_ops[o*32 +: 32] <= r_op_val[w_sel_idx][o];
                end
                r_out_ctrl           <= r_ctrl[w_sel_idx];
                r_out_id             <= RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(w_sel_idx);
                r_valid[w_sel_idx]   <= 1'b0;
            end else if (bus.output_ready) begin
                r_out_valid <= 1'b0;
            end

            // The taken slot is free at this edge, so it never collides with
            // the snooped or issued entries above.
            if (w_take) begin
                r_valid[w_free_idx] <= 1'b1;
                r_ctrl[w_free_idx]  <= bus.control_in;
                for (int o = 0; o < OPERANDS; o++) begin
                    r_op_tag[w_free_idx][o] <= bus.op_rs_id_in[o*RS_ID_WIDTH +: RS_ID_WIDTH];
                    if (bus.op_value_valid_in[o]) begin
                        r_op_valid[w_free_idx][o] <= 1'b1;
                        r_op_val[w_free_idx][o]   <= bus.op_value_in[o*32 +: 32];
                    end else begin
                        r_op_valid[w_free_idx][o] <= w_byp[o][32];
                        r_op_val[w_free_idx][o]   <= w_byp[o][31:0];
                    end
                end
                // Newest entry: younger than everyone, everyone older than it.
                r_older[w_free_idx] <= '0;
                for (int j = 0; j < RS_DEPTH; j++) begin
                    if (j != int'(w_free_idx)) begin
                        r_older[j][w_free_idx] <= 1'b1;
                    end
                end
            end

            r_occ <= r_occ + OCC_W'(w_take) - OCC_W'(w_load);
        end
    end

    assign bus.output_valid = r_out_valid;
    assign bus.op_value_out = r_out_ops;
    assign bus.control_out  = r_out_ctrl;
    assign bus.op_rs_id_out = r_out_id;
    assign bus.occupancy    = r_occ;
endmodule

// File: tb/tb_rs_multi_cdb.sv
module tb_rs_multi_cdb;
    localparam int OPS   = 4;
    localparam int IDW   = 5;
    localparam int DEPTH = 4;
    localparam int OFFS  = 8;
    localparam int PORTS = 2;
    localparam int CW    = 32;

    // One reservation-station entry as the model sees it.
    typedef struct packed {
        logic [IDW-1:0]           tag;
        logic [OPS-1:0]           v;
        logic [OPS-1:0][IDW-1:0]  t;
        logic [OPS-1:0][31:0]     val;
        logic [CW-1:0]            ctrl;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   chk_en   = 1'b0;
    bit   exp_ready;

    ent_t mq[$];        // held entries, oldest first
    bit   m_out_v;
    ent_t m_out;

    rs_multi_cdb_if #(.OPERANDS(OPS), .RS_ID_WIDTH(IDW), .RS_DEPTH(DEPTH),
                      .CDB_PORTS(PORTS), .CONTROL_WIDTH(CW)) bus ();

    rs_multi_cdb #(.OPERANDS(OPS), .RS_OFFSET(OFFS), .RS_DEPTH(DEPTH),
                   .RS_ID_WIDTH(IDW), .CDB_PORTS(PORTS), .CONTROL_WIDTH(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    endtask

    function automatic logic [IDW-1:0] free_tag();
        bit used;
        for (int k = 0; k < DEPTH; k++) begin
            used = 1'b0;
            foreach (mq[i]) if (mq[i].tag == IDW'(OFFS + k)) used = 1'b1;
            if (!used) return IDW'(OFFS + k);
        end
        return IDW'(OFFS);
    endfunction

    function automatic logic [32:0] cdb_find(input logic [IDW-1:0] tag);
        for (int p = 0; p < PORTS; p++) begin
            if (bus.cdb_valid[p] && bus.cdb_rs_id[p*IDW +: IDW] == tag)
                return {1'b1, bus.cdb_value[p*32 +: 32]};
        end
        return '0;
    endfunction

    // Model advance at each rising edge, using the inputs held during the cycle.
    task automatic model_step();
        ent_t        e;
        int          sel;
        bit          accept;
        logic [IDW-1:0] ntag;
        logic [32:0] hit;
        if (rst) begin
            mq.delete();
            m_out_v = 1'b0;
            m_out   = '0;
            return;
        end
        if (bus.flush) begin
            mq.delete();
            m_out_v = 1'b0;
            return;
        end
        accept = bus.take_valid && (mq.size() < DEPTH);
        ntag   = free_tag();
        sel    = -1;
        foreach (mq[i]) if (sel < 0 && mq[i].v == '1) sel = i;
        if (sel >= 0 && (!m_out_v || bus.output_ready)) begin
            m_out   = mq[sel];
            m_out_v = 1'b1;
            mq.delete(sel);
        end else if (bus.output_ready) begin
            m_out_v = 1'b0;
        end
        foreach (mq[i]) begin
            e = mq[i];
            for (int o = 0; o < OPS; o++) begin
                if (!e.v[o]) begin
                    hit = cdb_find(e.t[o]);
                    if (hit[32]) begin
                        e.v[o]   = 1'b1;
                        e.val[o] = hit[31:0];
                    end
                end
            end
            mq[i] = e;
        end
        if (accept) begin
            e.tag  = ntag;
            e.ctrl = bus.control_in;
            for (int o = 0; o < OPS; o++) begin
                e.t[o] = bus.op_rs_id_in[o*IDW +: IDW];
                if (bus.op_value_valid_in[o]) begin
                    e.v[o]   = 1'b1;
                    e.val[o] = bus.op_value_in[o*32 +: 32];
                end else begin
                    hit      = cdb_find(e.t[o]);
                    e.v[o]   = hit[32];
                    e.val[o] = hit[31:0];
                end
            end
            mq.push_back(e);
        end
    endtask

    always @(posedge clk) model_step();

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            exp_ready = !bus.flush && (mq.size() < DEPTH);
            chk("take_ready", bus.take_ready, exp_ready);
            if (exp_ready) chk("id_taken", bus.id_taken, free_tag());
            chk("occupancy", bus.occupancy, mq.size());
            chk("output_valid", bus.output_valid, m_out_v);
            if (m_out_v) begin
                chk("op_value_out", bus.op_value_out, m_out.val);
                chk("control_out", bus.control_out, m_out.ctrl);
                chk("op_rs_id_out", bus.op_rs_id_out, m_out.tag);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.flush             = 1'b0;
        bus.take_valid        = 1'b0;
        bus.op_value_valid_in = '0;
        bus.op_rs_id_in       = '0;
        bus.op_value_in       = '0;
        bus.control_in        = '0;
        bus.cdb_valid         = '0;
        bus.cdb_rs_id         = '0;
        bus.cdb_value         = '0;
        bus.output_ready      = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_take(input logic [OPS-1:0] v, input logic [OPS*IDW-1:0] tags,
                            input logic [OPS*32-1:0] vals, input logic [CW-1:0] ctrl);
        bus.take_valid        = 1'b1;
        bus.op_value_valid_in = v;
        bus.op_rs_id_in       = tags;
        bus.op_value_in       = vals;
        bus.control_in        = ctrl;
    endtask

    task automatic clr_take();
        bus.take_valid = 1'b0;
    endtask

    task automatic set_cdb(input int p, input logic [IDW-1:0] tag, input logic [31:0] val);
        bus.cdb_valid[p]          = 1'b1;
        bus.cdb_rs_id[p*IDW +: IDW] = tag;
        bus.cdb_value[p*32 +: 32] = val;
    endtask

    task automatic clr_cdb();
        bus.cdb_valid = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int full_ids[5];
        full_ids = '{8, 9, 8, 10, 11};
        idle();
        rst = 1'b1;
        repeat (2) tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        settle();
        chk("rst_output_valid", bus.output_valid, 0);
        chk("rst_occupancy", bus.occupancy, 0);
        chk("rst_op_value_out", bus.op_value_out, 0);
        chk("rst_control_out", bus.control_out, 0);
        chk("rst_op_rs_id_out", bus.op_rs_id_out, 0);
        chk("rst_take_ready", bus.take_ready, 1);
        chk("rst_id_taken", bus.id_taken, 8);

        // All operands valid: issue one cycle after the take edge.
        tick(); set_take(4'hF, '0, {32'd4, 32'd3, 32'd2, 32'd1}, 32'hC0); settle();
        chk("t1_id", bus.id_taken, 8);
        tick(); clr_take(); settle();
        chk("t1_occ1", bus.occupancy, 1);
        chk("t1_nv", bus.output_valid, 0);
        tick(); settle();
        chk("t1_ov", bus.output_valid, 1);
        chk("t1_ops", bus.op_value_out, {32'd4, 32'd3, 32'd2, 32'd1});
        chk("t1_tag", bus.op_rs_id_out, 8);
        chk("t1_occ0", bus.occupancy, 0);

        // A waits on tag 3, B ready: B overtakes, A follows the update.
        tick(); set_take(4'b1101, {5'd0, 5'd0, 5'd3, 5'd0}, {32'h40, 32'h30, 32'h0, 32'h10}, 32'hA); settle();
        chk("t2_idA", bus.id_taken, 8);
        tick(); set_take(4'hF, '0, {32'h8, 32'h7, 32'h6, 32'h5}, 32'hB); settle();
        chk("t2_idB", bus.id_taken, 9);
        tick(); clr_take(); settle();
        chk("t2_nv", bus.output_valid, 0);
        tick(); set_cdb(1, 5'd3, 32'hDEAD); settle();
        chk("t2_B_ov", bus.output_valid, 1);
        chk("t2_B_tag", bus.op_rs_id_out, 9);
        tick(); clr_cdb(); settle();
        chk("t2_gap", bus.output_valid, 0);
        tick(); settle();
        chk("t2_A_ov", bus.output_valid, 1);
        chk("t2_A_tag", bus.op_rs_id_out, 8);
        chk("t2_A_op2", bus.op_value_out[63:32], 32'hDEAD);

        // Dispatch bypass from port 0.
        tick(); set_take(4'b1110, {5'd0, 5'd0, 5'd0, 5'd5}, {32'h33, 32'h22, 32'h11, 32'h0}, 32'h3);
        set_cdb(0, 5'd5, 32'h55); settle();
        chk("t3_id", bus.id_taken, 8);
        tick(); clr_take(); clr_cdb(); settle();
        chk("t3_occ", bus.occupancy, 1);
        tick(); settle();
        chk("t3_ov", bus.output_valid, 1);
        chk("t3_op1", bus.op_value_out[31:0], 32'h55);

        // Fill with the output stage stalled. Tag 8 is reused once the first
        // entry moves out, so the oldest held entry is tag 9.
        for (int k = 0; k < 5; k++) begin
            tick();
            bus.output_ready = 1'b0;
            set_take(4'hF, '0, {4{32'(k + 32'h100)}}, 32'(32'h100 + k));
            settle();
            chk("t4_id", bus.id_taken, full_ids[k]);
        end
        tick(); set_take(4'hF, '0, {4{32'h105}}, 32'h105); settle();
        chk("t4_full_rdy", bus.take_ready, 0);
        chk("t4_full_occ", bus.occupancy, 4);
        chk("t4_full_tag", bus.op_rs_id_out, 8);
        chk("t4_full_ctrl", bus.control_out, 32'h100);
        tick(); settle();
        chk("t4_hold_tag", bus.op_rs_id_out, 8);
        tick(); bus.output_ready = 1'b1; settle();
        chk("t4_rel_rdy", bus.take_ready, 0);
        tick(); bus.output_ready = 1'b0; settle();
        chk("t4_free_rdy", bus.take_ready, 1);
        chk("t4_free_id", bus.id_taken, 9);
        chk("t4_next_tag", bus.op_rs_id_out, 9);
        tick(); clr_take(); bus.output_ready = 1'b1; settle();
        chk("t4_occ_after", bus.occupancy, 4);
        repeat (8) tick();

        // Both ports carry the same tag: port 0 wins.
        tick(); set_take(4'b1011, {5'd0, 5'd2, 5'd0, 5'd0}, {32'h4, 32'h0, 32'h2, 32'h1}, 32'h5);
        tick(); clr_take(); set_cdb(0, 5'd2, 32'h11); set_cdb(1, 5'd2, 32'h22);
        tick(); clr_cdb();
        tick(); settle();
        chk("t5_ov", bus.output_valid, 1);
        chk("t5_op3", bus.op_value_out[95:64], 32'h11);

        // Flush with a concurrent take.
        for (int k = 0; k < 4; k++) begin
            tick(); bus.output_ready = 1'b0;
            set_take(4'hF, '0, {4{32'(k + 32'h200)}}, 32'(32'h200 + k));
        end
        tick(); bus.flush = 1'b1; settle();
        chk("t6_occ3", bus.occupancy, 3);
        chk("t6_ov1", bus.output_valid, 1);
        chk("t6_rdy_flush", bus.take_ready, 0);
        tick(); bus.flush = 1'b0; clr_take(); bus.output_ready = 1'b1; settle();
        chk("t6_ov0", bus.output_valid, 0);
        chk("t6_occ0", bus.occupancy, 0);
        chk("t6_id", bus.id_taken, 8);
        chk("t6_rdy", bus.take_ready, 1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            tick();
            bus.flush      = ($urandom_range(0, 59) == 0);
            bus.take_valid = ($urandom_range(0, 2) != 0);
            for (int o = 0; o < OPS; o++) begin
                bus.op_value_valid_in[o]     = ($urandom_range(0, 9) < 6);
                bus.op_rs_id_in[o*IDW +: IDW] = IDW'($urandom_range(0, 7));
                bus.op_value_in[o*32 +: 32]  = $urandom;
            end
            bus.control_in = $urandom;
            for (int p = 0; p < PORTS; p++) begin
                bus.cdb_valid[p]            = ($urandom_range(0, 1) == 1);
                bus.cdb_rs_id[p*IDW +: IDW] = IDW'($urandom_range(0, 7));
                bus.cdb_value[p*32 +: 32]   = $urandom;
            end
            bus.output_ready = ($urandom_range(0, 3) != 0);
        end
        tick(); idle();
        repeat (10) tick();
        settle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
